// File: rtl/scoreboard_pkg.sv
// Shared types and hazard rule for the in-order scoreboard queue.
package scoreboard_pkg;

    localparam int unsigned SB_DEPTH    = 8;
    localparam int unsigned SB_XLEN     = 32;
    localparam int unsigned SB_REG_BITS = 5;
    localparam int unsigned SB_IDX_W    = $clog2(SB_DEPTH);

    localparam logic [SB_REG_BITS-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                   valid;
        logic                   running;
        logic [SB_IDX_W-1:0]    tag;
        logic [SB_XLEN-1:0]     instr;
        logic [SB_XLEN-1:0]     pc;
        logic [SB_REG_BITS-1:0] rs1;
        logic [SB_REG_BITS-1:0] rs2;
        logic [SB_REG_BITS-1:0] rd;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SLOT_HOLD,
        SLOT_SHIFT,
        SLOT_LOAD,
        SLOT_CLEAR
    } slot_op_t;

    // True when a live older entry blocks the younger one (RAW, WAW or WAR).
    function automatic logic hazard(input sb_entry_t older, input sb_entry_t younger);
        logic raw;
        logic waw;
        logic war;
        raw = (older.rd != REG_ZERO) && ((older.rd == younger.rs1) || (older.rd == younger.rs2));
        waw = (older.rd != REG_ZERO) && (older.rd == younger.rd);
        war = (younger.rd != REG_ZERO) && !older.running &&
              ((younger.rd == older.rs1) || (younger.rd == older.rs2));
        return older.valid && (raw || waw || war);
    endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One scoreboard slot: hold, shift in from the younger neighbour, load a new entry, or clear.
module scoreboard_entry
    import scoreboard_pkg::*;
(
    input  logic      clock,
    input  logic      reset_sync,
    input  slot_op_t  op,
    input  logic      set_running,
    input  sb_entry_t shift_in,
    input  sb_entry_t load_in,
    output sb_entry_t q,
    output sb_entry_t fwd
);

    // Post-dispatch view: the running bit lands before compaction so it travels with the entry.
    always_comb begin
        fwd = q;
        if (set_running) begin
            fwd.running = 1'b1;
        end
    end

    // Slot register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset_sync) begin
            q <= '0;
        end else begin
            case (op)
                SLOT_SHIFT: q <= shift_in;
                SLOT_LOAD:  q <= load_in;
                SLOT_CLEAR: q <= '0;
                default:    q <= fwd;
            endcase
        end
    end

endmodule

// File: rtl/scoreboard_queue.sv
// In-order scoreboard: issue append, hazard-aware dispatch, completion by tag with compaction.
module scoreboard_queue
    import scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH    = SB_DEPTH,
    parameter int unsigned XLEN     = SB_XLEN,
    parameter int unsigned REG_BITS = SB_REG_BITS,
    parameter int unsigned IDX_W    = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset_sync,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [XLEN-1:0]          issue_instr,
    input  logic [XLEN-1:0]          issue_pc,
    input  logic [REG_BITS-1:0]      issue_rs1,
    input  logic [REG_BITS-1:0]      issue_rs2,
    input  logic [REG_BITS-1:0]      issue_rd,
    output logic                     disp_valid,
    input  logic                     disp_ready,
    output logic [XLEN-1:0]          disp_instr,
    output logic [XLEN-1:0]          disp_pc,
    output logic [REG_BITS-1:0]      disp_rd,
    output logic [IDX_W-1:0]         disp_tag,
    input  logic                     cmpl_valid,
    input  logic [IDX_W-1:0]         cmpl_tag,
    output logic [IDX_W:0]           count,
    output logic [(2**REG_BITS)-1:0] busy_regs
);

    localparam int unsigned CW = IDX_W + 1;

    sb_entry_t          q        [DEPTH];
    sb_entry_t          fwd      [DEPTH];
    sb_entry_t          shift_in [DEPTH];
    slot_op_t           op       [DEPTH];
    sb_entry_t          new_entry;
    logic [DEPTH-1:0]   set_run;
    logic [DEPTH-1:0]   ready;
    logic [DEPTH-1:0]   tag_map;
    logic [DEPTH-1:0]   free_map;
    logic [IDX_W-1:0]   free_tag;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   cmpl_idx;
    logic               cmpl_hit;
    logic               disp_fire;
    logic               issue_fire;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      base;

    // Slot chain; the last slot shifts in an empty entry.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g == DEPTH - 1) begin : g_tail
            assign shift_in[g] = '0;
        end else begin : g_body
            assign shift_in[g] = fwd[g+1];
        end
        scoreboard_entry u_entry (
            .clock       (clock),
            .reset_sync  (reset_sync),
            .op          (op[g]),
            .set_running (set_run[g]),
            .shift_in    (shift_in[g]),
            .load_in     (new_entry),
            .q           (q[g]),
            .fwd         (fwd[g])
        );
    end

    // Hazard matrix: an entry is ready only if no older live entry blocks it.
    always_comb begin
        ready = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ready[i] = q[i].valid && !q[i].running;
            for (int unsigned j = 0; j < i; j++) begin
                if (hazard(q[j], q[i])) begin
                    ready[i] = 1'b0;
                end
            end
        end
    end

    // Priority pick of the oldest ready entry.
    always_comb begin
        sel = '0;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (ready[i-1]) begin
                sel = IDX_W'(i - 1);
            end
        end
    end

    assign disp_valid = |ready;
    assign disp_instr = q[sel].instr;
    assign disp_pc    = q[sel].pc;
    assign disp_rd    = q[sel].rd;
    assign disp_tag   = q[sel].tag;
    assign disp_fire  = disp_valid && disp_ready;

    // Completion only matches entries already running in registered state.
    always_comb begin
        cmpl_hit = 1'b0;
        cmpl_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cmpl_valid && q[i].valid && q[i].running && (q[i].tag == cmpl_tag)) begin
                cmpl_hit = 1'b1;
                cmpl_idx = IDX_W'(i);
            end
        end
    end

    // Tag allocation sees a tag freed in the same cycle, so it can be reused immediately.
    always_comb begin
        free_map = tag_map & ~(cmpl_hit ? (DEPTH'(1) << cmpl_tag) : '0);
        free_tag = '0;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (!free_map[i-1]) begin
                free_tag = IDX_W'(i - 1);
            end
        end
    end

    assign issue_ready = (count_q < CW'(DEPTH));
    assign issue_fire  = issue_valid && issue_ready;
    assign base        = count_q - CW'(cmpl_hit);

    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.tag     = free_tag;
        new_entry.instr   = issue_instr;
        new_entry.pc      = issue_pc;
        new_entry.rs1     = issue_rs1;
        new_entry.rs2     = issue_rs2;
        new_entry.rd      = issue_rd;
    end

    // Per-slot control: dispatch mark, then compaction, then append at the post-compaction tail.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            set_run[i] = disp_fire && (sel == IDX_W'(i));
            op[i]      = SLOT_HOLD;
            if (issue_fire && (CW'(i) == base)) begin
                op[i] = SLOT_LOAD;
            end else if (cmpl_hit && (IDX_W'(i) >= cmpl_idx) && (CW'(i) < count_q)) begin
                op[i] = (CW'(i) == count_q - CW'(1)) ? SLOT_CLEAR : SLOT_SHIFT;
            end
        end
    end

    // Occupancy count and tag-in-use bitmap.
    always_ff @(posedge clock) begin
        if (reset_sync) begin
            count_q <= '0;
            tag_map <= '0;
        end else begin
            count_q <= count_q + CW'(issue_fire) - CW'(cmpl_hit);
            tag_map <= free_map | (issue_fire ? (DEPTH'(1) << free_tag) : '0);
        end
    end

    assign count = count_q;

    // Destination registers owned by live entries; x0 never reported.
    always_comb begin
        busy_regs = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (q[i].valid && (q[i].rd != REG_ZERO)) begin
                busy_regs[q[i].rd] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_queue.sv
// Directed bench for scoreboard_queue with hand-computed expectations.
module tb_scoreboard_queue;

    logic        clock;
    logic        reset_sync;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        disp_valid;
    logic        disp_ready;
    logic [31:0] disp_instr;
    logic [31:0] disp_pc;
    logic [4:0]  disp_rd;
    logic [2:0]  disp_tag;
    logic        cmpl_valid;
    logic [2:0]  cmpl_tag;
    logic [3:0]  count;
    logic [31:0] busy_regs;

    int n_cmp = 0;
    int n_bad = 0;

    scoreboard_queue #(
        .DEPTH    (8),
        .XLEN     (32),
        .REG_BITS (5)
    ) dut (
        .clock       (clock),
        .reset_sync  (reset_sync),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_instr (issue_instr),
        .issue_pc    (issue_pc),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_instr  (disp_instr),
        .disp_pc     (disp_pc),
        .disp_rd     (disp_rd),
        .disp_tag    (disp_tag),
        .cmpl_valid  (cmpl_valid),
        .cmpl_tag    (cmpl_tag),
        .count       (count),
        .busy_regs   (busy_regs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle past it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_issue(input logic [31:0] instr, input logic [31:0] pc,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_instr = instr;
        issue_pc    = pc;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_rd    = rd;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        disp_ready  = 1'b0;
        cmpl_valid  = 1'b0;
        #1;
    endtask

    task automatic do_issue(input logic [31:0] instr, input logic [31:0] pc,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        set_issue(instr, pc, rs1, rs2, rd);
        cyc();
        idle();
    endtask

    task automatic do_dispatch();
        disp_ready = 1'b1;
        cyc();
        idle();
    endtask

    task automatic do_complete(input logic [2:0] tag);
        cmpl_valid = 1'b1;
        cmpl_tag   = tag;
        cyc();
        idle();
    endtask

    initial begin
        reset_sync  = 1'b1;
        issue_valid = 1'b0;
        issue_instr = '0;
        issue_pc    = '0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        issue_rd    = '0;
        disp_ready  = 1'b0;
        cmpl_valid  = 1'b0;
        cmpl_tag    = '0;
        cyc();
        cyc();
        reset_sync = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_ready", issue_ready, 1);
        check("rst_disp", disp_valid, 0);
        check("rst_busy", busy_regs, 0);

        // RAW: B reads A's destination
        do_issue(32'h11, 32'h100, 5'd1, 5'd2, 5'd3);
        do_issue(32'h22, 32'h104, 5'd3, 5'd4, 5'd6);
        check("raw_count", count, 2);
        check("raw_busy", busy_regs, 32'h48);
        check("raw_disp_tag", disp_tag, 0);
        check("raw_disp_instr", disp_instr, 32'h11);
        check("raw_disp_pc", disp_pc, 32'h100);
        do_dispatch();
        check("raw_blocked", disp_valid, 0);
        do_complete(3'd0);
        check("raw_freed_valid", disp_valid, 1);
        check("raw_freed_tag", disp_tag, 1);
        check("raw_freed_rd", disp_rd, 6);
        check("raw_after_count", count, 1);
        check("raw_after_busy", busy_regs, 32'h40);

        // Spurious completions: non-running entry, then unused tag
        do_complete(3'd1);
        check("spur_nr_count", count, 1);
        check("spur_nr_tag", disp_tag, 1);
        do_complete(3'd5);
        check("spur_free_count", count, 1);
        check("spur_free_busy", busy_regs, 32'h40);
        do_dispatch();
        do_complete(3'd1);
        check("raw_empty", count, 0);

        // WAW: same destination
        do_issue(32'h33, 32'h108, 5'd0, 5'd0, 5'd5);
        do_issue(32'h44, 32'h10c, 5'd1, 5'd2, 5'd5);
        check("waw_disp_tag", disp_tag, 0);
        do_dispatch();
        check("waw_blocked", disp_valid, 0);
        do_complete(3'd0);
        check("waw_freed_tag", disp_tag, 1);
        check("waw_freed_instr", disp_instr, 32'h44);
        do_dispatch();
        do_complete(3'd1);

        // WAR: D writes a register C still has to read
        do_issue(32'h55, 32'h110, 5'd0, 5'd7, 5'd0);
        do_issue(32'h66, 32'h114, 5'd0, 5'd0, 5'd7);
        check("war_busy", busy_regs, 32'h80);
        check("war_disp_tag", disp_tag, 0);
        do_dispatch();
        check("war_unblocked", disp_valid, 1);
        check("war_unblocked_tag", disp_tag, 1);
        do_dispatch();
        do_complete(3'd0);
        do_complete(3'd1);
        check("war_empty", count, 0);

        // Fill with independent entries, first with instr 0
        for (int i = 0; i < 8; i++) begin
            do_issue(32'(i), 32'h200 + 32'(4 * i), 5'd0, 5'd0, 5'(8 + i));
        end
        check("full_count", count, 8);
        check("full_ready", issue_ready, 0);
        check("full_busy", busy_regs, 32'hff00);
        do_issue(32'h99, 32'h300, 5'd0, 5'd0, 5'd20);
        check("full_ignored_count", count, 8);
        check("full_ignored_busy", busy_regs, 32'hff00);
        disp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("fill_disp_tag", disp_tag, 64'(i));
            check("fill_disp_instr", disp_instr, 64'(i));
            cyc();
        end
        idle();
        check("fill_all_running", disp_valid, 0);
        do_complete(3'd3);
        check("cmpl3_count", count, 7);
        check("cmpl3_ready", issue_ready, 1);
        check("cmpl3_busy", busy_regs, 32'hf700);

        // Refill: freed tag 3 reused
        do_issue(32'ha0, 32'h400, 5'd0, 5'd0, 5'd16);
        check("refill_tag", disp_tag, 3);
        check("refill_count", count, 8);

        // Full + complete + issue: issue refused
        set_issue(32'hb0, 32'h404, 5'd0, 5'd0, 5'd17);
        cmpl_valid = 1'b1;
        cmpl_tag   = 3'd7;
        cyc();
        idle();
        check("fci_count", count, 7);
        check("fci_busy", busy_regs, 32'h17700);
        check("fci_shift_tag", disp_tag, 3);
        check("fci_shift_instr", disp_instr, 32'ha0);

        // Dispatch + complete + issue in one cycle
        set_issue(32'hc0, 32'h408, 5'd0, 5'd0, 5'd18);
        disp_ready = 1'b1;
        cmpl_valid = 1'b1;
        cmpl_tag   = 3'd1;
        cyc();
        idle();
        check("dci_count", count, 7);
        check("dci_new_tag", disp_tag, 1);
        check("dci_new_instr", disp_instr, 32'hc0);
        check("dci_busy", busy_regs, 32'h57500);
        do_complete(3'd3);
        check("dci_run_moved", count, 6);

        // Spurious on the non-running new entry, and on a free tag
        do_complete(3'd1);
        check("spur2_nr_count", count, 6);
        do_complete(3'd7);
        check("spur2_free_count", count, 6);
        check("spur2_busy", busy_regs, 32'h47500);

        // Reset mid-run wins over a concurrent issue
        set_issue(32'hdd, 32'h500, 5'd0, 5'd0, 5'd9);
        reset_sync = 1'b1;
        cyc();
        reset_sync = 1'b0;
        idle();
        check("mid_rst_count", count, 0);
        check("mid_rst_disp", disp_valid, 0);
        check("mid_rst_busy", busy_regs, 0);
        do_issue(32'h77, 32'h600, 5'd0, 5'd0, 5'd4);
        check("mid_rst_tag", disp_tag, 0);
        check("mid_rst_count1", count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
